// File: rtl/uart_tx_engine.sv
// UART transmit engine: drains a show-ahead TX FIFO and serialises each byte as an
// 8N1-style frame on tx, using 16x oversampled bit timing from an internal divider.
//
// state | meaning
// IDLE  | line high, waiting for a non-empty FIFO
// START | start bit (tx=0) for 16 ticks
// DATA  | DBIT data bits, LSB first, 16 ticks each
// STOP  | stop bit(s) (tx=1) for SB_TICK ticks
module uart_tx_engine #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_dout,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int SMAX = (SB_TICK - 1 > 15) ? SB_TICK - 1 : 15;
  localparam int SW   = $clog2(SMAX + 1);
  localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int TW   = (DVSR > 1) ? $clog2(DVSR) : 1;

  localparam logic [SW-1:0] S_LAST_BIT  = SW'(15);
  localparam logic [SW-1:0] S_LAST_STOP = SW'(SB_TICK - 1);
  localparam logic [BW-1:0] B_LAST      = BW'(DBIT - 1);
  localparam logic [TW-1:0] T_LAST      = TW'(DVSR - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]     samp_q, samp_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DBIT-1:0]   shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic              tx_busy_q, tx_busy_d;
  logic              tx_done_q, tx_done_d;
  logic              tick;

  assign tick = (tick_cnt_q == T_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      samp_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      fifo_rd_q  <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      fifo_rd_q  <= fifo_rd_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_rd_d  = 1'b0;
    tx_done_d  = 1'b0;

    // Divider held at zero while idle so each frame starts on a fresh tick boundary.
    if (state_q == IDLE) tick_cnt_d = '0;
    else                 tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          shift_d   = fifo_dout;
          fifo_rd_d = 1'b1;
          tx_d      = 1'b0;
          samp_d    = '0;
          bit_d     = '0;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          if (samp_q == S_LAST_BIT) begin
            samp_d  = '0;
            bit_d   = '0;
            tx_d    = shift_q[0];
            state_d = DATA;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (samp_q == S_LAST_BIT) begin
            samp_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == B_LAST) begin
              tx_d    = 1'b1;
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
              tx_d  = shift_d[0];
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (samp_q == S_LAST_STOP) begin
            samp_d    = '0;
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_busy_d = (state_d != IDLE);
  end

  assign tx           = tx_q;
  assign fifo_rd      = fifo_rd_q;
  assign tx_busy      = tx_busy_q;
  assign tx_done_tick = tx_done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: three configurations (DVSR=1, DVSR=4, SB_TICK=32) fed from
// FIFO models; a monitor rebuilds each frame from tx and checks it against queued bytes.
module tb_uart_tx_engine;

  localparam int NI = 3;

  logic            clk = 1'b0;
  logic [NI-1:0]   rst_v = '0;
  logic [NI-1:0]   empty_v = '1;
  logic [7:0]      dout_a [NI];
  logic [NI-1:0]   rd_w, tx_w, busy_w, done_w;

  always #5 clk = ~clk;

  function automatic int dv_of(int i);
    return (i == 1) ? 4 : 1;
  endfunction

  function automatic int sb_of(int i);
    return (i == 2) ? 32 : 16;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_engine #(
      .DBIT(8), .SB_TICK(g == 2 ? 32 : 16), .DVSR(g == 1 ? 4 : 1)
    ) u_dut (
      .clk(clk), .reset(rst_v[g]), .fifo_empty(empty_v[g]), .fifo_dout(dout_a[g]),
      .fifo_rd(rd_w[g]), .tx(tx_w[g]), .tx_busy(busy_w[g]), .tx_done_tick(done_w[g])
    );
  end

  logic [7:0] fifo_q [NI][$];
  logic [7:0] exp_q  [NI][$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en = 1'b0, final_req = 1'b0, final_done = 1'b0;

  bit         act       [NI];
  bit         exp_start [NI];
  int         t_f       [NI];
  logic [7:0] cur_b     [NI];
  logic [7:0] rx_b      [NI];
  int         last_start[NI];
  int         last_done [NI];

  task automatic chk(string name, int i, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h", name, i, cyc, got, want);
    end
  endtask

  // Expected line behaviour: idle high; a frame is start(16*DVSR clocks low), 8 data
  // bits LSB first of 16*DVSR clocks each, stop high SB_TICK*DVSR clocks, then done.
  task automatic mon_step(int i);
    int bitc, endt, lvl;
    bit start_now;
    bitc = 16 * dv_of(i);
    endt = 9 * bitc + sb_of(i) * dv_of(i);
    if (rst_v[i]) begin
      chk("rst_tx",   i, int'(tx_w[i]),   1);
      chk("rst_busy", i, int'(busy_w[i]), 0);
      chk("rst_rd",   i, int'(rd_w[i]),   0);
      chk("rst_done", i, int'(done_w[i]), 0);
      act[i] = 1'b0;
      exp_start[i] = 1'b0;
      last_done[i] = -10;
      return;
    end
    start_now = !act[i] && (tx_w[i] == 1'b0);
    if (!act[i]) begin
      chk("start_timing", i, int'(start_now), int'(exp_start[i]));
      if (start_now) begin
        chk("frame_expected", i, int'(exp_q[i].size() > 0), 1);
        cur_b[i] = (exp_q[i].size() > 0) ? exp_q[i].pop_front() : 8'h00;
        if (cyc - last_done[i] == 1)
          chk("b2b_period", i, cyc - last_start[i], (16 * 9 + sb_of(i)) * dv_of(i) + 1);
        last_start[i] = cyc;
        act[i] = 1'b1;
        t_f[i] = 0;
        rx_b[i] = '0;
      end else begin
        chk("idle_tx",   i, int'(tx_w[i]),   1);
        chk("idle_busy", i, int'(busy_w[i]), 0);
        chk("idle_rd",   i, int'(rd_w[i]),   0);
        chk("idle_done", i, int'(done_w[i]), 0);
      end
    end
    if (act[i]) begin
      if (t_f[i] < bitc)          lvl = 0;
      else if (t_f[i] < 9 * bitc) lvl = int'(cur_b[i][t_f[i] / bitc - 1]);
      else                        lvl = 1;
      chk("tx_level", i, int'(tx_w[i]), lvl);
      chk("rd_strobe", i, int'(rd_w[i]), (t_f[i] == 0) ? 1 : 0);
      if (t_f[i] >= bitc && t_f[i] < 9 * bitc && (t_f[i] % bitc) == bitc / 2)
        rx_b[i][t_f[i] / bitc - 1] = tx_w[i];
      if (t_f[i] == endt) begin
        chk("done_tick", i, int'(done_w[i]), 1);
        chk("done_busy", i, int'(busy_w[i]), 0);
        chk("rx_byte",   i, int'(rx_b[i]), int'(cur_b[i]));
        act[i] = 1'b0;
        last_done[i] = cyc;
      end else begin
        chk("frame_busy", i, int'(busy_w[i]), 1);
        chk("frame_done", i, int'(done_w[i]), 0);
      end
      t_f[i]++;
    end
    exp_start[i] = !act[i] && !empty_v[i];
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      act[i] = 1'b0; exp_start[i] = 1'b0; t_f[i] = 0;
      cur_b[i] = '0; rx_b[i] = '0; last_start[i] = 0; last_done[i] = -10;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en)
        for (int i = 0; i < NI; i++) mon_step(i);
      if (final_req && !final_done) begin
        for (int i = 0; i < NI; i++) begin
          chk("exp_drained",  i, exp_q[i].size(), 0);
          chk("frame_closed", i, int'(act[i]), 0);
        end
        final_done = 1'b1;
      end
    end
  end

  task automatic drive_fifo();
    for (int i = 0; i < NI; i++) begin
      empty_v[i] = (fifo_q[i].size() == 0);
      dout_a[i]  = (fifo_q[i].size() == 0) ? 8'($urandom) : fifo_q[i][0];
    end
  endtask

  task automatic push(int i, logic [7:0] b);
    fifo_q[i].push_back(b);
    exp_q[i].push_back(b);
    drive_fifo();
  endtask

  task automatic step(int n);
    logic [NI-1:0] rd_s;
    repeat (n) begin
      rd_s = rd_w;
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++)
        if (rd_s[i] && fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
      drive_fifo();
    end
  endtask

  function automatic bit all_idle();
    bit r;
    r = (busy_w == '0);
    for (int i = 0; i < NI; i++)
      if (fifo_q[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  initial begin
    drive_fifo();
    #2 rst_v = '1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(3);
    rst_v = '0;
    step(3);

    // Single frames per configuration, plus a back-to-back pair on SB_TICK=32.
    push(0, 8'hA5);
    push(1, 8'h3C);
    push(2, 8'h00);
    push(2, 8'h00);
    step(700);

    // Back-to-back pair at DVSR=1, then a long idle stretch.
    push(0, 8'h55);
    push(0, 8'h0F);
    step(400);
    step(1000);

    // Reset during data bit 3 of 0xFF; the byte is lost and the line stays idle.
    push(0, 8'hFF);
    step(1 + 16 * 4 + 6);
    rst_v[0] = 1'b1;
    step(5);
    rst_v[0] = 1'b0;
    step(200);

    // A byte queued while held in reset goes out after release.
    rst_v[0] = 1'b1;
    push(0, 8'h81);
    step(4);
    rst_v[0] = 1'b0;
    step(200);

    // Random traffic, including pushes that land mid-frame.
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < NI; i++)
        if ($urandom_range(0, 1) == 1) push(i, 8'($urandom));
      step($urandom_range(20, 500));
    end

    for (int k = 0; k < 20000 && !all_idle(); k++) step(1);
    step(2);
    final_req = 1'b1;
    step(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
